pc_gen: RTL and testbench

Parametrised program-counter generator for the rvseed core: owns the PC register, computes the next PC, and sequences fetch. Successor to the combinational next-PC selector. It adds:
- configurable width, reset vector and instruction alignment;
- a fetch request/acknowledge handshake;
- trap and mret redirection;
- target-misalignment detection, halt/resume control and a retired-instruction counter.

It sits between the execute-stage control outputs and the instruction-fetch port.

---
 rtl/pc_gen_pkg.sv | 29 ++
 rtl/pc_target.sv | 60 ++++++
 rtl/pc_gen.sv | 130 +++++++++++++
 tb/tb_pc_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared encodings for the program-counter generator.
// Holds branch/jump type codes, the fetch FSM state codes and
// a small alignment helper used by the target datapath.
package pc_gen_pkg;

  // Branch type encoding (execute-stage control)
  localparam int BRAN_WIDTH = 2;
  localparam logic [BRAN_WIDTH-1:0] BRAN_NONE   = 2'd0;
  localparam logic [BRAN_WIDTH-1:0] BRAN_TYPE_A = 2'd1;  // taken when zero
  localparam logic [BRAN_WIDTH-1:0] BRAN_TYPE_B = 2'd2;  // taken when not zero

  // Jump type encoding
  localparam int JUMP_WIDTH = 2;
  localparam logic [JUMP_WIDTH-1:0] JUMP_NONE = 2'd0;
  localparam logic [JUMP_WIDTH-1:0] JUMP_JAL  = 2'd1;
  localparam logic [JUMP_WIDTH-1:0] JUMP_JALR = 2'd2;

  // Fetch sequencer states
  localparam logic [1:0] PCG_BOOT = 2'd0;
  localparam logic [1:0] PCG_RUN  = 2'd1;
  localparam logic [1:0] PCG_HALT = 2'd2;

  // With 32-bit alignment a set bit 1 is illegal; with 16-bit alignment
  // bit 0 is always cleared upstream so nothing can be misaligned.
  function automatic logic is_misaligned(input logic bit1, input int ialign);
    return (ialign == 32) && bit1;
  endfunction

endpackage

// File: rtl/pc_target.sv
// Combinational next-PC target select with misalignment detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output simply tracks the inputs.
module pc_target
  import pc_gen_pkg::*;
#(
  parameter int CPU_WIDTH = 32,
  parameter int IALIGN    = 32
) (
  input  logic [CPU_WIDTH-1:0]  curr_pc_i,
  input  logic [BRAN_WIDTH-1:0] branch_i,
  input  logic                  zero_i,
  input  logic [JUMP_WIDTH-1:0] jump_i,
  input  logic [CPU_WIDTH-1:0]  reg1_rdata_i,
  input  logic [CPU_WIDTH-1:0]  imm_i,
  input  logic                  trap_i,
  input  logic [CPU_WIDTH-1:0]  trap_vec_i,
  input  logic                  mret_i,
  input  logic [CPU_WIDTH-1:0]  mepc_i,
  output logic [CPU_WIDTH-1:0]  target_o,
  output logic                  misaligned_o
);

  logic [CPU_WIDTH-1:0] pc_plus_imm;
  logic [CPU_WIDTH-1:0] pc_plus_4;
  logic [CPU_WIDTH-1:0] jalr_tgt;
  logic                 taken;
  logic                 check_align;

  // Adders (modulo 2^CPU_WIDTH) and the jalr bit-0 clear
  always_comb begin
    pc_plus_imm = curr_pc_i + imm_i;
    pc_plus_4   = curr_pc_i + CPU_WIDTH'(4);
    jalr_tgt    = (reg1_rdata_i + imm_i) & ~CPU_WIDTH'(1);
    taken       = ((branch_i == BRAN_TYPE_A) &&  zero_i) ||
                  ((branch_i == BRAN_TYPE_B) && !zero_i);
  end

  // Priority select; only control-flow targets are alignment-checked
  always_comb begin
    target_o    = pc_plus_4;
    check_align = 1'b0;
    if (trap_i) begin
      target_o = trap_vec_i;
    end else if (mret_i) begin
      target_o = mepc_i;
    end else if (taken) begin
      target_o    = pc_plus_imm;
      check_align = 1'b1;
    end else if (jump_i == JUMP_JAL) begin
      target_o    = pc_plus_imm;
      check_align = 1'b1;
    end else if (jump_i == JUMP_JALR) begin
      target_o    = jalr_tgt;
      check_align = 1'b1;
    end
    misaligned_o = check_align && is_misaligned(target_o[1], IALIGN);
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter register, fetch sequencing (BOOT/RUN/HALT) and instret.
// Latency: curr_pc takes next_pc one cycle after a commit; next_pc is combinational.
// Backpressure: ena=0 or if_ack=0 stalls the PC, counter and FSM.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_VEC = '0,
  parameter int                   IALIGN    = 32,
  parameter int                   CNT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  output logic                  if_req,
  input  logic                  if_ack,
  input  logic [BRAN_WIDTH-1:0] branch,
  input  logic                  zero,
  input  logic [JUMP_WIDTH-1:0] jump,
  input  logic [CPU_WIDTH-1:0]  reg1_rdata,
  input  logic [CPU_WIDTH-1:0]  imm,
  input  logic                  trap,
  input  logic [CPU_WIDTH-1:0]  trap_vec,
  input  logic                  mret,
  input  logic [CPU_WIDTH-1:0]  mepc,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [CPU_WIDTH-1:0]  curr_pc,
  output logic [CPU_WIDTH-1:0]  next_pc,
  output logic                  misalign,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  instret
);

  logic [1:0]           state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 halt_pend_q, halt_pend_d;

  logic [CPU_WIDTH-1:0] target;
  logic                 tgt_misaligned;
  logic                 commit;

  pc_target #(
    .CPU_WIDTH (CPU_WIDTH),
    .IALIGN    (IALIGN)
  ) u_target (
    .curr_pc_i    (pc_q),
    .branch_i     (branch),
    .zero_i       (zero),
    .jump_i       (jump),
    .reg1_rdata_i (reg1_rdata),
    .imm_i        (imm),
    .trap_i       (trap),
    .trap_vec_i   (trap_vec),
    .mret_i       (mret),
    .mepc_i       (mepc),
    .target_o     (target),
    .misaligned_o (tgt_misaligned)
  );

  // A misaligned control-flow target is redirected to the trap handler
  always_comb begin
    next_pc = tgt_misaligned ? trap_vec : target;
    commit  = (state_q == PCG_RUN) && if_ack && ena;
  end

  // FSM, PC, misalign pulse, halt latch and retired-instruction counter
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    instret_d   = instret_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      PCG_BOOT: state_d = PCG_RUN;
      PCG_RUN: begin
        if (commit) begin
          pc_d       = next_pc;
          misalign_d = tgt_misaligned;
          // Trap-redirected commits do not retire an instruction
          if (!trap && !tgt_misaligned) begin
            instret_d = instret_q + CNT_WIDTH'(1);
          end
          if (halt_req || halt_pend_q) begin
            state_d     = PCG_HALT;
            halt_pend_d = 1'b0;
          end
        end else if (halt_req) begin
          // Remember the request until the next commit
          halt_pend_d = 1'b1;
        end
      end
      PCG_HALT: begin
        if (trap) begin
          pc_d    = trap_vec;
          state_d = PCG_RUN;
        end else if (resume && !halt_req) begin
          state_d = PCG_RUN;
        end
      end
      default: state_d = PCG_BOOT;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PCG_BOOT;
      pc_q        <= RESET_VEC;
      misalign_q  <= 1'b0;
      instret_q   <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      instret_q   <= instret_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign curr_pc  = pc_q;
  assign misalign = misalign_q;
  assign instret  = instret_q;
  assign if_req   = (state_q == PCG_RUN);
  assign halted   = (state_q == PCG_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: two instances (IALIGN 32 and 16) share stimulus.
// Latency: each step is one clock; outputs sampled 1 time unit after the edge.
// Backpressure: ena is toggled to exercise the stall path.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        if_ack;
  logic [1:0]  branch;
  logic        zero;
  logic [1:0]  jump;
  logic [31:0] reg1_rdata;
  logic [31:0] imm;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic        halt_req;
  logic        resume;

  logic        a_if_req, b_if_req;
  logic [31:0] a_curr_pc, b_curr_pc;
  logic [31:0] a_next_pc, b_next_pc;
  logic        a_misalign, b_misalign;
  logic        a_halted, b_halted;
  logic [63:0] a_instret, b_instret;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_gen #(.CPU_WIDTH(32), .RESET_VEC(32'h100), .IALIGN(32), .CNT_WIDTH(64)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .if_req(a_if_req), .if_ack(if_ack),
    .branch(branch), .zero(zero), .jump(jump), .reg1_rdata(reg1_rdata), .imm(imm),
    .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
    .halt_req(halt_req), .resume(resume),
    .curr_pc(a_curr_pc), .next_pc(a_next_pc), .misalign(a_misalign),
    .halted(a_halted), .instret(a_instret)
  );

  pc_gen #(.CPU_WIDTH(32), .RESET_VEC(32'h100), .IALIGN(16), .CNT_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .if_req(b_if_req), .if_ack(if_ack),
    .branch(branch), .zero(zero), .jump(jump), .reg1_rdata(reg1_rdata), .imm(imm),
    .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
    .halt_req(halt_req), .resume(resume),
    .curr_pc(b_curr_pc), .next_pc(b_next_pc), .misalign(b_misalign),
    .halted(b_halted), .instret(b_instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; if_ack = 1'b1; branch = BRAN_NONE; zero = 1'b0;
    jump = JUMP_NONE; reg1_rdata = '0; imm = '0; trap = 1'b0; trap_vec = 32'h80;
    mret = 1'b0; mepc = 32'h40; halt_req = 1'b0; resume = 1'b0;
    #1;
    chk("rst_pc", 64'(a_curr_pc), 64'h100);
    chk("rst_if_req", 64'(a_if_req), 64'h0);
    chk("rst_halted", 64'(a_halted), 64'h0);
    chk("rst_misalign", 64'(a_misalign), 64'h0);
    chk("rst_instret", a_instret, 64'h0);
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("boot_if_req", 64'(a_if_req), 64'h0);
    step();
    chk("run_if_req", 64'(a_if_req), 64'h1);
    chk("run_pc", 64'(a_curr_pc), 64'h100);
    step();
    chk("seq1_pc", 64'(a_curr_pc), 64'h104);
    step();
    chk("seq2_pc", 64'(a_curr_pc), 64'h108);
    chk("seq2_instret", a_instret, 64'd2);

    // jal to 0x200
    jump = JUMP_JAL; imm = 32'hF8; #1;
    chk("jal_next_pc", 64'(a_next_pc), 64'h200);
    step();
    chk("jal_pc", 64'(a_curr_pc), 64'h200);
    // BRAN_TYPE_B, zero=0: taken backwards
    jump = JUMP_NONE; branch = BRAN_TYPE_B; zero = 1'b0; imm = 32'hFFFF_FFF0;
    step();
    chk("bran_b_taken", 64'(a_curr_pc), 64'h1F0);
    branch = BRAN_NONE; jump = JUMP_JAL; imm = 32'h10;
    step();
    chk("jal_back", 64'(a_curr_pc), 64'h200);
    // BRAN_TYPE_B, zero=1: not taken
    jump = JUMP_NONE; branch = BRAN_TYPE_B; zero = 1'b1; imm = 32'hFFFF_FFF0;
    step();
    chk("bran_b_not_taken", 64'(a_curr_pc), 64'h204);
    chk("instret_6", a_instret, 64'd6);

    // jalr clears bit 0
    branch = BRAN_NONE; zero = 1'b0; jump = JUMP_JALR; reg1_rdata = 32'h301; imm = 32'h0;
    step();
    chk("jalr_a_pc", 64'(a_curr_pc), 64'h300);
    chk("jalr_b_pc", 64'(b_curr_pc), 64'h300);
    // jalr to 0x302: misaligned only for 32-bit alignment
    imm = 32'h2; #1;
    chk("mis_next_pc", 64'(a_next_pc), 64'h80);
    chk("ial16_next_pc", 64'(b_next_pc), 64'h302);
    step();
    chk("mis_pc", 64'(a_curr_pc), 64'h80);
    chk("mis_pulse", 64'(a_misalign), 64'h1);
    chk("mis_instret", a_instret, 64'd7);
    chk("ial16_pc", 64'(b_curr_pc), 64'h302);
    chk("ial16_no_mis", 64'(b_misalign), 64'h0);
    chk("ial16_instret", b_instret, 64'd8);
    // jalr to top of address space
    reg1_rdata = 32'hFFFF_FFFC; imm = 32'h0;
    step();
    chk("mis_pulse_end", 64'(a_misalign), 64'h0);
    chk("top_pc", 64'(a_curr_pc), 64'hFFFF_FFFC);
    jump = JUMP_NONE;
    step();
    chk("wrap_pc", 64'(a_curr_pc), 64'h0);
    chk("wrap_instret", a_instret, 64'd9);

    // stall for three cycles
    ena = 1'b0;
    repeat (3) step();
    chk("stall_pc", 64'(a_curr_pc), 64'h0);
    chk("stall_instret", a_instret, 64'd9);
    chk("stall_next_pc", 64'(a_next_pc), 64'h4);
    ena = 1'b1;

    // trap beats mret, and is not counted
    trap = 1'b1; mret = 1'b1;
    step();
    chk("trap_pc", 64'(a_curr_pc), 64'h80);
    chk("trap_instret", a_instret, 64'd9);
    trap = 1'b0;
    step();
    chk("mret_pc", 64'(a_curr_pc), 64'h40);
    chk("mret_instret", a_instret, 64'd10);
    mret = 1'b0;

    // halt at a commit
    halt_req = 1'b1;
    step();
    chk("halt_pc", 64'(a_curr_pc), 64'h44);
    chk("halt_halted", 64'(a_halted), 64'h1);
    chk("halt_if_req", 64'(a_if_req), 64'h0);
    chk("halt_instret", a_instret, 64'd11);
    halt_req = 1'b0;
    step();
    chk("halt_hold_pc", 64'(a_curr_pc), 64'h44);
    resume = 1'b1; halt_req = 1'b1;
    step();
    chk("resume_vs_halt", 64'(a_halted), 64'h1);
    halt_req = 1'b0;
    step();
    chk("resume_halted", 64'(a_halted), 64'h0);
    chk("resume_if_req", 64'(a_if_req), 64'h1);
    chk("resume_pc", 64'(a_curr_pc), 64'h44);
    resume = 1'b0; halt_req = 1'b1;
    step();
    chk("halt2_pc", 64'(a_curr_pc), 64'h48);
    chk("halt2_halted", 64'(a_halted), 64'h1);
    halt_req = 1'b0;
    // trap while halted restarts at the handler
    trap = 1'b1;
    step();
    chk("halt_trap_pc", 64'(a_curr_pc), 64'h80);
    chk("halt_trap_run", 64'(a_halted), 64'h0);
    chk("halt_trap_instret", a_instret, 64'd12);
    trap = 1'b0; halt_req = 1'b1;
    step();
    chk("halt3_pc", 64'(a_curr_pc), 64'h84);
    chk("halt3_halted", 64'(a_halted), 64'h1);
    halt_req = 1'b0;

    // asynchronous reset while halted
    rst = 1'b1;
    #1;
    chk("rst2_pc", 64'(a_curr_pc), 64'h100);
    chk("rst2_halted", 64'(a_halted), 64'h0);
    chk("rst2_if_req", 64'(a_if_req), 64'h0);
    chk("rst2_instret", a_instret, 64'h0);
    chk("rst2_misalign", 64'(a_misalign), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
